// File: rtl/diff_pkg.sv
// Shared types for the difftest commit buffer: the packed commit record,
// the per-entry state and the captured store-completion payload.
package diff_pkg;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        skip;
        logic        wen;
        logic [7:0]  wdest;
        logic [63:0] wdata;
        logic        is_store;
        logic        excp_valid;
        logic        is_mret;
        logic [31:0] intrpt_no;
        logic [31:0] cause;
    } commit_rec_t;

    localparam int REC_W = $bits(commit_rec_t);

    typedef enum logic [1:0] {
        ENT_EMPTY   = 2'd0,
        ENT_WAIT_ST = 2'd1,
        ENT_READY   = 2'd2
    } ent_state_e;

    typedef struct packed {
        logic [63:0] paddr;
        logic [63:0] vaddr;
        logic [63:0] data;
        logic [7:0]  mask;
    } store_info_t;

endpackage

// File: rtl/diff_commit_buffer.sv
// In-order commit buffer feeding the difftest bridge: store records are held
// until their LSU completion arrives, then every record is emitted in program order.
module diff_commit_buffer
    import diff_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TMO   = 255
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [REC_W-1:0] in_rec,
    input  logic             st_valid,
    input  logic [63:0]      st_paddr,
    input  logic [63:0]      st_vaddr,
    input  logic [63:0]      st_data,
    input  logic [7:0]       st_mask,
    output logic             out_valid,
    output logic [7:0]       out_index,
    output logic [REC_W-1:0] out_rec,
    output logic [7:0]       out_store_valid,
    output logic [63:0]      out_store_paddr,
    output logic [63:0]      out_store_vaddr,
    output logic [63:0]      out_store_data,
    output logic [63:0]      commit_cnt,
    output logic             err_orphan,
    output logic             err_timeout
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [31:0]   TMO_C    = 32'(TMO);

    commit_rec_t   rec_mem [DEPTH];
    store_info_t   st_mem  [DEPTH];
    ent_state_e    state_q [DEPTH];
    logic [AW-1:0] wptr, rptr, sptr;
    logic [AW:0]   count, wait_cnt;
    logic [31:0]   tmo_cnt;

    commit_rec_t   in_r;
    store_info_t   st_in;
    logic          push, push_store, push_wait;
    logic          have_wait, fill, fill_head, direct, orphan;
    logic          head_wait, pop;
    commit_rec_t   pop_rec;
    store_info_t   pop_st;
    logic [AW-1:0] next_wait, scan_idx;

    assign in_r  = in_rec;
    assign st_in = '{paddr: st_paddr, vaddr: st_vaddr, data: st_data, mask: st_mask};

    // Handshake: a record transfers on any rising edge where in_valid && in_ready;
    // in_ready depends only on occupancy, never on in_valid.
    assign in_ready = (count < FULL_CNT);

    always_comb begin
        push       = in_valid && in_ready;
        push_store = push && in_r.is_store;
        have_wait  = (wait_cnt != '0);
        fill       = st_valid && have_wait;
        direct     = st_valid && !have_wait && push_store;
        orphan     = st_valid && !have_wait && !push_store;
        push_wait  = push_store && !direct;
        head_wait  = (count != '0) && (state_q[rptr] == ENT_WAIT_ST);
        // When the head waits it is by definition the oldest waiting store.
        fill_head  = fill && (sptr == rptr);

        // An empty queue forwards a complete incoming record straight to the outputs.
        if (count == '0) begin
            pop     = push && !push_wait;
            pop_rec = in_r;
            pop_st  = st_in;
        end else begin
            pop     = (state_q[rptr] == ENT_READY) || fill_head;
            pop_rec = rec_mem[rptr];
            pop_st  = fill_head ? st_in : st_mem[rptr];
        end

        // Next-oldest waiting store after sptr; only entries younger than sptr can qualify.
        next_wait = sptr;
        scan_idx  = '0;
        for (int i = DEPTH - 1; i >= 1; i--) begin
            scan_idx = sptr + AW'(i);
            if (state_q[scan_idx] == ENT_WAIT_ST) begin
                next_wait = scan_idx;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                state_q[i] <= ENT_EMPTY;
            end
            wptr            <= '0;
            rptr            <= '0;
            sptr            <= '0;
            count           <= '0;
            wait_cnt        <= '0;
            tmo_cnt         <= '0;
            out_valid       <= 1'b0;
            out_index       <= '0;
            out_rec         <= '0;
            out_store_valid <= '0;
            out_store_paddr <= '0;
            out_store_vaddr <= '0;
            out_store_data  <= '0;
            commit_cnt      <= '0;
            err_orphan      <= 1'b0;
            err_timeout     <= 1'b0;
        end else begin
            out_valid <= pop;

            if (push) begin
                rec_mem[wptr] <= in_r;
                st_mem[wptr]  <= st_in;
                state_q[wptr] <= push_wait ? ENT_WAIT_ST : ENT_READY;
                wptr          <= wptr + PTR_ONE;
            end

            if (fill) begin
                st_mem[sptr]  <= st_in;
                state_q[sptr] <= ENT_READY;
            end

            // Placed last so a same-cycle fill or bypass push of the head ends EMPTY.
            if (pop) begin
                state_q[rptr] <= ENT_EMPTY;
                rptr          <= rptr + PTR_ONE;
                out_index     <= commit_cnt[7:0];
                commit_cnt    <= commit_cnt + 64'd1;
                out_rec       <= pop_rec;
                if (pop_rec.is_store) begin
                    out_store_valid <= pop_st.mask;
                    out_store_paddr <= pop_st.paddr;
                    out_store_vaddr <= pop_st.vaddr;
                    out_store_data  <= pop_st.data;
                end else begin
                    out_store_valid <= '0;
                    out_store_paddr <= '0;
                    out_store_vaddr <= '0;
                    out_store_data  <= '0;
                end
            end

            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase

            wait_cnt <= wait_cnt + (AW + 1)'(push_wait) - (AW + 1)'(fill);

            if (fill) begin
                if (wait_cnt > CNT_ONE) begin
                    sptr <= next_wait;
                end else if (push_wait) begin
                    sptr <= wptr;
                end
            end else if (push_wait && !have_wait) begin
                sptr <= wptr;
            end

            if (orphan) begin
                err_orphan <= 1'b1;
            end

            // Saturating wait counter; the entry keeps waiting after the flag is raised.
            if (head_wait && !fill_head) begin
                if (tmo_cnt >= TMO_C) begin
                    err_timeout <= 1'b1;
                end
                if (tmo_cnt <= TMO_C) begin
                    tmo_cnt <= tmo_cnt + 32'd1;
                end
            end else begin
                tmo_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_diff_commit_buffer.sv
// Bench for diff_commit_buffer: directed scenarios plus random traffic, checked by a
// program-order queue model feeding an expected-commit scoreboard.
module tb_diff_commit_buffer;
    import diff_pkg::*;

    localparam int DEPTH = 4;
    localparam int TMO   = 255;
    localparam int EXP_W = 8 + REC_W + 8 + 64 * 3;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [REC_W-1:0] in_rec = '0;
    logic             st_valid = 1'b0;
    logic [63:0]      st_paddr = '0;
    logic [63:0]      st_vaddr = '0;
    logic [63:0]      st_data = '0;
    logic [7:0]       st_mask = '0;
    logic             out_valid;
    logic [7:0]       out_index;
    logic [REC_W-1:0] out_rec;
    logic [7:0]       out_store_valid;
    logic [63:0]      out_store_paddr;
    logic [63:0]      out_store_vaddr;
    logic [63:0]      out_store_data;
    logic [63:0]      commit_cnt;
    logic             err_orphan;
    logic             err_timeout;

    commit_rec_t o_rec;
    assign o_rec = out_rec;

    always #5 clock = ~clock;

    diff_commit_buffer #(.DEPTH(DEPTH), .TMO(TMO)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_rec(in_rec),
        .st_valid(st_valid), .st_paddr(st_paddr), .st_vaddr(st_vaddr),
        .st_data(st_data), .st_mask(st_mask),
        .out_valid(out_valid), .out_index(out_index), .out_rec(out_rec),
        .out_store_valid(out_store_valid), .out_store_paddr(out_store_paddr),
        .out_store_vaddr(out_store_vaddr), .out_store_data(out_store_data),
        .commit_cnt(commit_cnt), .err_orphan(err_orphan), .err_timeout(err_timeout)
    );

    typedef struct {
        commit_rec_t rec;
        logic        filled;
        store_info_t st;
    } pend_t;

    pend_t            pend_q[$];
    logic [EXP_W-1:0] exp_q[$];
    int               checks = 0;
    int               errors = 0;
    logic [7:0]       model_idx = '0;
    logic [63:0]      model_cnt = '0;
    logic             model_orphan = 1'b0;
    longint           acc_total = 0;
    longint           mon_cnt = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Scoreboard monitor: every emitted commit is matched against the head of exp_q.
    always @(negedge clock) begin
        logic [EXP_W-1:0] got;
        logic [EXP_W-1:0] e;
        if (reset) begin
            mon_cnt = 0;
        end else if (out_valid) begin
            got = {out_index, out_rec, out_store_valid, out_store_paddr, out_store_vaddr, out_store_data};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL commit_unexpected: got index %0h pc %0h expected no commit", out_index, o_rec.pc);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    errors++;
                    $display("FAIL commit: got %0h expected %0h", got, e);
                end
            end
            mon_cnt++;
            check("commit_cnt", commit_cnt, 64'(mon_cnt));
        end
    end

    function automatic commit_rec_t rand_rec(input logic st, input logic [63:0] pc);
        commit_rec_t r;
        r.pc         = pc;
        r.instr      = $urandom;
        r.skip       = 1'($urandom_range(0, 1));
        r.wen        = 1'($urandom_range(0, 1));
        r.wdest      = 8'($urandom_range(0, 255));
        r.wdata      = {$urandom, $urandom};
        r.is_store   = st;
        r.excp_valid = 1'($urandom_range(0, 1));
        r.is_mret    = 1'($urandom_range(0, 1));
        r.intrpt_no  = $urandom;
        r.cause      = $urandom;
        return r;
    endfunction

    function automatic int unfilled_stores();
        int n = 0;
        foreach (pend_q[i]) if (!pend_q[i].filled) n++;
        return n;
    endfunction

    // Model: program-order list; completions go to the oldest unfilled store;
    // complete records at the front become expected commits with consecutive indices.
    task automatic model_step(input logic acc, input commit_rec_t r, input logic sv, input store_info_t s);
        pend_t p;
        logic  found = 1'b0;
        if (acc) begin
            p.rec    = r;
            p.filled = !r.is_store;
            p.st     = '0;
            pend_q.push_back(p);
        end
        if (sv) begin
            for (int i = 0; i < pend_q.size(); i++) begin
                if (!found && !pend_q[i].filled) begin
                    p = pend_q[i];
                    p.filled = 1'b1;
                    p.st = s;
                    pend_q[i] = p;
                    found = 1'b1;
                end
            end
            if (!found) model_orphan = 1'b1;
        end
        while (pend_q.size() != 0 && pend_q[0].filled) begin
            p = pend_q.pop_front();
            if (p.rec.is_store)
                exp_q.push_back({model_idx, p.rec, p.st.mask, p.st.paddr, p.st.vaddr, p.st.data});
            else
                exp_q.push_back({model_idx, p.rec, 8'h00, 64'h0, 64'h0, 64'h0});
            model_idx++;
            model_cnt++;
        end
    endtask

    // Starts and ends at a falling edge; inputs change 1 time unit after it.
    task automatic step(input logic iv, input commit_rec_t r, input logic sv,
                        input logic [7:0] m, input logic [63:0] d);
        store_info_t s;
        logic        exp_ready;
        #1;
        reset    = 1'b0;
        s.paddr  = {$urandom, $urandom};
        s.vaddr  = {$urandom, $urandom};
        s.data   = d;
        s.mask   = m;
        in_valid = iv;
        in_rec   = r;
        st_valid = sv;
        st_paddr = s.paddr;
        st_vaddr = s.vaddr;
        st_data  = d;
        st_mask  = m;
        exp_ready = (acc_total - mon_cnt) < DEPTH;
        check("in_ready", {63'h0, in_ready}, {63'h0, exp_ready});
        if (iv && exp_ready) acc_total++;
        model_step(iv && exp_ready, r, sv, s);
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 8'h00, 64'h0);
    endtask

    task automatic do_reset();
        #1;
        reset    = 1'b1;
        in_valid = 1'b0;
        st_valid = 1'b0;
        check("scoreboard_empty_at_reset", 64'(exp_q.size()), 64'h0);
        exp_q.delete();
        pend_q.delete();
        model_idx    = '0;
        model_cnt    = '0;
        model_orphan = 1'b0;
        acc_total    = 0;
        @(negedge clock);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"}, {63'h0, out_valid}, 64'h0);
        check({tag, "_out_index"}, {56'h0, out_index}, 64'h0);
        check({tag, "_out_rec_pc"}, o_rec.pc, 64'h0);
        check({tag, "_out_rec_nonzero"}, {63'h0, |out_rec}, 64'h0);
        check({tag, "_store_valid"}, {56'h0, out_store_valid}, 64'h0);
        check({tag, "_store_paddr"}, out_store_paddr, 64'h0);
        check({tag, "_store_vaddr"}, out_store_vaddr, 64'h0);
        check({tag, "_store_data"}, out_store_data, 64'h0);
        check({tag, "_commit_cnt"}, commit_cnt, 64'h0);
        check({tag, "_err_orphan"}, {63'h0, err_orphan}, 64'h0);
        check({tag, "_err_timeout"}, {63'h0, err_timeout}, 64'h0);
        check({tag, "_in_ready"}, {63'h0, in_ready}, 64'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        commit_rec_t r;
        logic        iv, st, sv;
        int          n;

        @(negedge clock);
        do_reset();
        check_reset_outputs("reset");

        // Non-store into an empty queue commits on the next cycle.
        step(1'b1, rand_rec(1'b0, 64'h8000_0000), 1'b0, 8'h00, 64'h0);
        check("bypass_valid", {63'h0, out_valid}, 64'h1);
        check("bypass_index", {56'h0, out_index}, 64'h0);
        check("bypass_pc", o_rec.pc, 64'h8000_0000);
        check("bypass_store_valid", {56'h0, out_store_valid}, 64'h0);

        // Store waits for its completion three cycles later.
        step(1'b1, rand_rec(1'b1, 64'h8000_0004), 1'b0, 8'h00, 64'h0);
        check("store_wait_no_commit", {63'h0, out_valid}, 64'h0);
        idle(2);
        check("store_still_waiting", {63'h0, out_valid}, 64'h0);
        step(1'b0, '0, 1'b1, 8'h0F, 64'hDEAD);
        check("store_commit_valid", {63'h0, out_valid}, 64'h1);
        check("store_commit_pc", o_rec.pc, 64'h8000_0004);
        check("store_commit_mask", {56'h0, out_store_valid}, 64'h0F);
        check("store_commit_data", out_store_data, 64'hDEAD);
        idle(1);
        check("store_hold_mask", {56'h0, out_store_valid}, 64'h0F);

        // Waiting store at the head blocks three younger non-stores and fills the queue.
        step(1'b1, rand_rec(1'b1, 64'h8000_0100), 1'b0, 8'h00, 64'h0);
        for (int i = 1; i < 4; i++) begin
            step(1'b1, rand_rec(1'b0, 64'h8000_0100 + 64'(4 * i)), 1'b0, 8'h00, 64'h0);
            check("blocked_no_commit", {63'h0, out_valid}, 64'h0);
        end
        check("full_in_ready", {63'h0, in_ready}, 64'h0);
        step(1'b1, rand_rec(1'b0, 64'h8000_0200), 1'b0, 8'h00, 64'h0);
        check("full_reject_no_commit", {63'h0, out_valid}, 64'h0);
        step(1'b0, '0, 1'b1, 8'hF0, {$urandom, $urandom});
        check("drain_0", {63'h0, out_valid}, 64'h1);
        for (int i = 1; i < 4; i++) begin
            idle(1);
            check("drain_consecutive", {63'h0, out_valid}, 64'h1);
        end
        idle(1);
        check("drain_done", {63'h0, out_valid}, 64'h0);

        // Index wrap over 256 commits.
        do_reset();
        for (int i = 0; i < 257; i++) begin
            step(1'b1, rand_rec(1'b0, 64'h9000_0000 + 64'(4 * i)), 1'b0, 8'h00, 64'h0);
            if (i == 255) begin
                check("wrap_index_255", {56'h0, out_index}, 64'hFF);
                check("wrap_commit_cnt", commit_cnt, 64'd256);
            end
        end
        check("wrap_index_0", {56'h0, out_index}, 64'h0);
        idle(1);

        // Orphan completion and head timeout.
        do_reset();
        step(1'b0, '0, 1'b1, 8'h01, 64'h1);
        check("orphan_set", {63'h0, err_orphan}, 64'h1);
        step(1'b1, rand_rec(1'b1, 64'hA000_0000), 1'b0, 8'h00, 64'h0);
        idle(200);
        check("timeout_not_yet", {63'h0, err_timeout}, 64'h0);
        idle(60);
        check("timeout_set", {63'h0, err_timeout}, 64'h1);
        step(1'b0, '0, 1'b1, 8'h3C, 64'hBEEF);
        check("timeout_entry_kept", {63'h0, out_valid}, 64'h1);
        check("timeout_entry_data", out_store_data, 64'hBEEF);
        idle(1);

        // Reset with two waiting stores discards them.
        do_reset();
        step(1'b1, rand_rec(1'b1, 64'hB000_0000), 1'b0, 8'h00, 64'h0);
        step(1'b1, rand_rec(1'b1, 64'hB000_0004), 1'b0, 8'h00, 64'h0);
        do_reset();
        check_reset_outputs("midreset");
        step(1'b0, '0, 1'b1, 8'hFF, 64'h5);
        check("post_reset_orphan", {63'h0, err_orphan}, 64'h1);
        check("post_reset_no_commit", {63'h0, out_valid}, 64'h0);

        // Random traffic.
        do_reset();
        for (int i = 0; i < 800; i++) begin
            iv = ($urandom_range(0, 99) < 60);
            st = ($urandom_range(0, 99) < 30);
            if (unfilled_stores() != 0) sv = ($urandom_range(0, 99) < 45);
            else if (iv && st) sv = ($urandom_range(0, 99) < 50);
            else sv = ($urandom_range(0, 99) < 3);
            r = rand_rec(st, {$urandom, $urandom});
            step(iv, r, sv, 8'($urandom_range(0, 255)), {$urandom, $urandom});
        end
        n = 0;
        while ((pend_q.size() != 0 || exp_q.size() != 0) && n < 200) begin
            step(1'b0, '0, (unfilled_stores() != 0), 8'($urandom_range(1, 255)), {$urandom, $urandom});
            n++;
        end
        check("random_drain", 64'(pend_q.size() + exp_q.size()), 64'h0);
        check("random_commit_cnt", commit_cnt, model_cnt);
        check("random_err_orphan", {63'h0, err_orphan}, {63'h0, model_orphan});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/diff_commit_buffer.md
DIFF_COMMIT_BUFFER -- requirements
Module: diff_commit_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of commit-record entries (power of 2, at least 2).
REQ-002 SHALL have parameter TMO, default 255, maximum number of cycles a head entry may wait for its store completion.
REQ-003 SHALL have one clock; reset is synchronous and active-high; ports are named clock and reset.
REQ-004 SHALL have the following ports (name  direction  width  meaning):
- clock  input  1  sole clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  WB stage retires one instruction.
- in_ready  output  1  buffer can accept a record.
- in_rec  input  REC_W  packed commit record: pc[63:0], instr[31:0], skip, wen, wdest[7:0], wdata[63:0], is_store, excp_valid, is_mret, intrpt_no[31:0], cause[31:0].
- st_valid  input  1  LSU store write response completed.
- st_paddr  input  64  physical address of the completed store.
- st_vaddr  input  64  virtual address of the completed store.
- st_data  input  64  data of the completed store.
- st_mask  input  8  byte-valid mask of the completed store.
- out_valid  output  1  instrValid to the difftest bridge.
- out_index  output  8  commit index.
- out_rec  output  REC_W  record of the emitted commit.
- out_store_valid  output  8  store mask, 0 if the record is not a store.
- out_store_paddr  output  64  store physical address.
- out_store_vaddr  output  64  store virtual address.
- out_store_data  output  64  store data.
- commit_cnt  output  64  total number of commits emitted.
- err_orphan  output  1  sticky: a store completion arrived with no store waiting for it.
- err_timeout  output  1  sticky: the head store entry waited longer than TMO cycles.

Function
REQ-005 SHALL implement a circular queue with write pointer wptr, read pointer rptr and a count; in_ready SHALL be (count < DEPTH) and SHALL NOT depend on in_valid.
REQ-006 SHALL push the record on (in_valid && in_ready); pointers wrap from DEPTH-1 to 0; a full queue with in_valid=1 SHALL hold in_ready=0 and leave contents unchanged.
REQ-007 SHALL give each entry a state from {EMPTY, WAIT_ST, READY}; a push with is_store=0 enters READY; a push with is_store=1 enters WAIT_ST.
REQ-008 SHALL treat store completions as arriving in program order; st_valid SHALL fill the oldest WAIT_ST entry, tracked by pointer sptr, and move that entry to READY.
REQ-009 SHALL, when st_valid arrives in the same cycle as a store push and no older WAIT_ST entry exists, write the new entry directly as READY with the store fields filled.
REQ-010 SHALL, when st_valid arrives and no entry is waiting (WAIT_ST or same-cycle store push), set err_orphan and discard the completion.
REQ-011 SHALL, on each cycle where the head entry is READY, pop it and register it onto the outputs, so that out_valid=1 for exactly that next cycle; a maximum of one commit is emitted per cycle.
REQ-012 SHALL give a latency of 1 cycle from push to out_valid for a non-store record arriving into an empty queue.
REQ-013 SHALL allow a push and a pop in the same cycle; count is unchanged in that case.
REQ-014 SHALL drive out_store_valid = st_mask for store records and 8'h00 otherwise; all out_* fields other than out_valid SHALL hold their last values when out_valid=0.
REQ-015 SHALL increment out_index by 1 per emitted commit, wrapping from 255 to 0; the first commit after reset SHALL carry index 0.
REQ-016 SHALL increment commit_cnt (64-bit) by 1 per emitted commit.
REQ-017 SHALL count cycles while the head entry is in WAIT_ST; when the count exceeds TMO, SHALL set err_timeout and continue waiting without discarding the entry.

Reset
REQ-018 SHALL, on reset, clear all entries to EMPTY, set wptr, rptr, sptr and count to 0, and clear the timeout counter.
REQ-019 SHALL, on reset, drive out_valid=0, out_index=0, out_rec=0, all out_store_* = 0, commit_cnt=0, err_orphan=0 and err_timeout=0; in_ready SHALL read 1 in the first cycle after reset.
REQ-020 SHALL, on reset asserted mid-operation, discard all pending entries including WAIT_ST entries; no commit is emitted during the reset cycle.

Structure
REQ-021 SHALL place the commit-record struct, REC_W, and the entry-state enum in the shared package diff_pkg.
REQ-022 SHALL be implemented as a single module with no sub-modules; the queue is not a generic FIFO because entries are updated in place.

Verification
REQ-023 Bench SHALL cover: push non-store pc=0x80000000 into an empty queue -> out_valid the next cycle with pc=0x80000000, index=0, store_valid=0.
REQ-024 Bench SHALL cover: push store pc=0x80000004, then st_valid 3 cycles later with mask=0x0F and data=0xDEAD -> out_valid 1 cycle after st_valid, store_valid=0x0F, data=0xDEAD.
REQ-025 Bench SHALL cover: a store at the head waiting, followed by 3 non-stores -> queue full, in_ready=0; no non-store is emitted before the store; after st_valid all 4 records are emitted on consecutive cycles in order.
REQ-026 Bench SHALL cover: 256 non-store commits -> out_index wraps from 255 to 0 and commit_cnt=256.
REQ-027 Bench SHALL cover: st_valid into an empty queue -> err_orphan=1; a store head with no st_valid for 256 cycles -> err_timeout=1.
REQ-028 Bench SHALL cover: reset asserted with 2 WAIT_ST entries pending -> all outputs 0 and in_ready=1; a later st_valid sets err_orphan.
